sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 27 ++
 rtl/sdram_arbiter_slot_timer.sv | 41 ++++
 rtl/sdram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM arbiter and any block that talks to the
// same memory controller: arbiter state encoding, default slot/refresh
// timing, and a width helper for counters sized from those parameters.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_LOAD = 2'd2,
    ST_REFR = 2'd3
  } arb_state_e;

  // Clocks a loader or forced-refresh slot holds its strobe low.
  localparam int unsigned SLOT_DEFAULT  = 32'd8;
  // Clocks without any refresh before a refresh is forced.
  localparam int unsigned RFMAX_DEFAULT = 32'd1024;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sdram_arbiter_slot_timer.sv
// Loadable down-counter that times a fixed-length SDRAM slot. Loaded with
// SLOT-1 on slot entry, it counts down while enabled and flags the last
// clock of the slot on tc_o.
module sdram_arbiter_slot_timer #(
  parameter int unsigned W = 32'd3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload on slot entry, otherwise count down toward zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared by reset so an aborted slot leaves no residue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i & (cnt_q == {W{1'b0}});

endmodule

// File: rtl/sdram_arbiter.sv
// Arbiter sharing one SDRAM controller between a CPU (combinational
// pass-through), a loader (fixed-length write slots) and forced refresh
// slots that keep the memory alive when the CPU stops refreshing.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned SLOT  = SLOT_DEFAULT,
  parameter int unsigned RFMAX = RFMAX_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        cpuRf,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [23:0] cpuA,
  input  logic [15:0] cpuD,
  output logic [15:0] cpuQ,
  output logic        cpuWait,
  input  logic        ldReq,
  input  logic [23:0] ldA,
  input  logic [15:0] ldD,
  output logic        ldAck,
  output logic        sdrRf,
  output logic        sdrRd,
  output logic        sdrWr,
  output logic [23:0] sdrA,
  output logic [15:0] sdrD,
  input  logic [15:0] sdrQ
);

  localparam int unsigned SLOT_W = cnt_width(SLOT);
  localparam int unsigned RF_W   = cnt_width(RFMAX + 32'd1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT - 32'd1);
  localparam logic [RF_W-1:0]   RF_LAST   = RF_W'(RFMAX - 32'd1);

  arb_state_e state_q;
  arb_state_e state_d;

  logic [RF_W-1:0] rfcnt_q;
  logic [RF_W-1:0] rfcnt_d;
  logic            pend_q;
  logic            pend_d;
  logic [15:0]     cpuq_q;
  logic [15:0]     cpuq_d;
  logic [23:0]     lda_q;
  logic [23:0]     lda_d;
  logic [15:0]     ldd_q;
  logic [15:0]     ldd_d;

  logic cpu_any_s;
  logic cpu_req_s;
  logic rf_due_s;
  logic in_slot_s;
  logic slot_load_s;
  logic slot_tc_s;

  assign cpu_any_s   = ~cpuRf | ~cpuRd | ~cpuWr;
  assign cpu_req_s   = ready & cpu_any_s;
  assign rf_due_s    = (rfcnt_q == RF_LAST);
  assign in_slot_s   = (state_q == ST_LOAD) || (state_q == ST_REFR);
  assign slot_load_s = (state_q == ST_IDLE) &&
                       ((state_d == ST_LOAD) || (state_d == ST_REFR));

  sdram_arbiter_slot_timer #(
    .W (SLOT_W)
  ) u_slot_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (slot_load_s),
    .load_val_i (SLOT_LAST),
    .en_i       (in_slot_s),
    .tc_o       (slot_tc_s)
  );

  // FSM state register; reset drops any slot in progress back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: strict CPU > refresh > loader priority from IDLE; slots
  // always run to their terminal count once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_s) begin
          state_d = ST_CPU;
        end else if (rf_due_s && ready) begin
          state_d = ST_REFR;
        end else if (ldReq && ready) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CPU: begin
        if (cpu_req_s) begin
          state_d = ST_CPU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD, ST_REFR: begin
        if (slot_tc_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: CPU passes straight through in IDLE/CPU (strobes only while
  // the controller is ready); slots drive their own strobe and address.
  always_comb begin
    sdrRf = 1'b1;
    sdrRd = 1'b1;
    sdrWr = 1'b1;
    sdrA  = 24'h000000;
    sdrD  = 16'h0000;
    ldAck = 1'b0;
    if (!reset) begin
      ldAck = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_CPU: begin
          sdrA = cpuA;
          sdrD = cpuD;
          if (ready) begin
            sdrRf = cpuRf;
            sdrRd = cpuRd;
            sdrWr = cpuWr;
          end else begin
            sdrRf = 1'b1;
          end
        end
        ST_LOAD: begin
          sdrWr = 1'b0;
          sdrA  = lda_q;
          sdrD  = ldd_q;
          ldAck = slot_tc_s;
        end
        ST_REFR: begin
          sdrRf = 1'b0;
        end
        default: begin
          sdrRf = 1'b1;
        end
      endcase
    end
  end

  assign cpuWait = ~pend_q;
  assign cpuQ    = cpuq_q;

  // Datapath next values: refresh age, CPU-pending flag, read data and
  // the loader address/data latched at slot entry.
  always_comb begin
    rfcnt_d = rfcnt_q;
    pend_d  = 1'b0;
    cpuq_d  = cpuq_q;
    lda_d   = lda_q;
    ldd_d   = ldd_q;

    // Any refresh reaching the controller restarts the age count.
    if (sdrRf == 1'b0) begin
      rfcnt_d = {RF_W{1'b0}};
    end else if (rfcnt_q != RF_LAST) begin
      rfcnt_d = rfcnt_q + RF_W'(1);
    end else begin
      rfcnt_d = rfcnt_q;
    end

    // CPU held off by a slot waits until the slot's last clock; it is then
    // granted from IDLE in the following clock.
    if (in_slot_s && !slot_tc_s) begin
      pend_d = pend_q | cpu_any_s;
    end else begin
      pend_d = 1'b0;
    end

    if ((state_q == ST_CPU) && !cpuRd) begin
      cpuq_d = sdrQ;
    end else begin
      cpuq_d = cpuq_q;
    end

    if (slot_load_s && (state_d == ST_LOAD)) begin
      lda_d = ldA;
      ldd_d = ldD;
    end else begin
      lda_d = lda_q;
      ldd_d = ldd_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rfcnt_q <= {RF_W{1'b0}};
      pend_q  <= 1'b0;
      cpuq_q  <= 16'h0000;
      lda_q   <= 24'h000000;
      ldd_q   <= 16'h0000;
    end else begin
      rfcnt_q <= rfcnt_d;
      pend_q  <= pend_d;
      cpuq_q  <= cpuq_d;
      lda_q   <= lda_d;
      ldd_q   <= ldd_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: CPU pass-through, loader slots,
// forced refresh, collisions, priority, ready gating and mid-slot reset.
module tb_sdram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic        cpuRf, cpuRd, cpuWr;
  logic [23:0] cpuA;
  logic [15:0] cpuD;
  logic [15:0] cpuQ;
  logic        cpuWait;
  logic        ldReq;
  logic [23:0] ldA;
  logic [15:0] ldD;
  logic        ldAck;
  logic        sdrRf, sdrRd, sdrWr;
  logic [23:0] sdrA;
  logic [15:0] sdrD;
  logic [15:0] sdrQ;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;

  logic [39:0] ld_exp_q[$];
  logic [15:0] rd_exp_q[$];
  logic [39:0] mon_exp;

  sdram_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .ready   (ready),
    .cpuRf   (cpuRf),
    .cpuRd   (cpuRd),
    .cpuWr   (cpuWr),
    .cpuA    (cpuA),
    .cpuD    (cpuD),
    .cpuQ    (cpuQ),
    .cpuWait (cpuWait),
    .ldReq   (ldReq),
    .ldA     (ldA),
    .ldD     (ldD),
    .ldAck   (ldAck),
    .sdrRf   (sdrRf),
    .sdrRd   (sdrRd),
    .sdrWr   (sdrWr),
    .sdrA    (sdrA),
    .sdrD    (sdrD),
    .sdrQ    (sdrQ)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge. Sample point: falling edge.
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  // Loader scoreboard: every ldAck must match the oldest queued write.
  always @(negedge clock) begin
    if (reset === 1'b1 && ldAck === 1'b1) begin
      ack_cnt++;
      if (ld_exp_q.size() > 0) begin
        mon_exp = ld_exp_q.pop_front();
        check_eq("ldack_addr", {8'h00, sdrA}, {8'h00, mon_exp[39:16]});
        check_eq("ldack_data", {16'h0000, sdrD}, {16'h0000, mon_exp[15:0]});
      end else begin
        check_eq("ldack_unexpected", 32'(ld_exp_q.size()), 32'd1);
      end
    end
  end

  // One CPU refresh pulse; restarts the refresh age and leaves the DUT idle.
  task automatic cpu_refresh();
    cpuRf = 1'b0;
    smp();
    check_eq("cpurf_pass", {31'd0, sdrRf}, 32'd0);
    nxt();
    cpuRf = 1'b1;
    smp();
    nxt();
  endtask

  // Follow a loader slot from the IDLE clock to ldAck, counting write clocks.
  task automatic wait_slot(input int drop_at, output int low_clk, output int got_ack);
    low_clk = 0;
    got_ack = 0;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (sdrWr === 1'b0) low_clk++;
      if (ldAck === 1'b1) got_ack = 1;
      nxt();
      if (k == drop_at) begin
        ldReq = 1'b0;
        ldA   = 24'hFFFFFF;
        ldD   = 16'hDEAD;
      end
      if (got_ack != 0) break;
    end
    ldReq = 1'b0;
  endtask

  task automatic run_load(input logic [23:0] a, input logic [15:0] d, input int drop_at,
                          output int low_clk, output int got_ack);
    ldReq = 1'b1;
    ldA   = a;
    ldD   = d;
    ld_exp_q.push_back({a, d});
    wait_slot(drop_at, low_clk, got_ack);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first;
    int low;
    int ack;
    int cnt;
    int acks0;
    int kind;
    int prev;
    int glog[$];

    reset = 1'b0;
    ready = 1'b1;
    cpuRf = 1'b0;
    cpuRd = 1'b1;
    cpuWr = 1'b1;
    cpuA  = 24'hABCDEF;
    cpuD  = 16'h1234;
    ldReq = 1'b0;
    ldA   = 24'h000000;
    ldD   = 16'h0000;
    sdrQ  = 16'h0000;

    // Reset values, even with a CPU strobe and address applied.
    repeat (2) smp();
    check_eq("rst_strobes", {29'd0, sdrRf, sdrRd, sdrWr}, 32'd7);
    check_eq("rst_sdrA", {8'h00, sdrA}, 32'd0);
    check_eq("rst_sdrD", {16'h0000, sdrD}, 32'd0);
    check_eq("rst_cpuQ", {16'h0000, cpuQ}, 32'd0);
    check_eq("rst_ldAck", {31'd0, ldAck}, 32'd0);
    check_eq("rst_cpuWait", {31'd0, cpuWait}, 32'd1);

    nxt();
    cpuRf = 1'b1;
    cpuA  = 24'h000000;
    cpuD  = 16'h0000;
    reset = 1'b1;

    // Forced refresh after 1024 idle clocks, lasting 8 clocks.
    first = 0;
    for (int i = 1; i <= 1100; i++) begin
      nxt();
      smp();
      if (sdrRf === 1'b0) begin
        first = i;
        break;
      end
    end
    check_eq("refr_start", first, 32'd1024);
    check_eq("refr_rdwr", {30'd0, sdrRd, sdrWr}, 32'd3);
    low = 1;
    for (int i = 0; i < 20; i++) begin
      nxt();
      smp();
      if (sdrRf === 1'b0) low++;
      else break;
    end
    check_eq("refr_len", low, 32'd8);
    nxt();

    // A CPU refresh before the deadline prevents the forced refresh.
    cnt = 0;
    for (int i = 0; i < 900; i++) begin
      nxt();
      smp();
      if (sdrRf === 1'b0) cnt++;
    end
    nxt();
    cpu_refresh();
    for (int i = 0; i < 600; i++) begin
      smp();
      if (sdrRf === 1'b0) cnt++;
      nxt();
    end
    check_eq("no_forced_refr", cnt, 32'd0);

    // CPU read passes through in the same clock; data latched into cpuQ.
    cpu_refresh();
    cpuRd = 1'b0;
    cpuA  = 24'h014000;
    sdrQ  = 16'h00A5;
    rd_exp_q.push_back(16'h00A5);
    smp();
    check_eq("cpu_rd_pass", {31'd0, sdrRd}, 32'd0);
    check_eq("cpu_rd_addr", {8'h00, sdrA}, 32'h014000);
    check_eq("cpu_rd_wait", {31'd0, cpuWait}, 32'd1);
    nxt();
    smp();
    nxt();
    cpuRd = 1'b1;
    sdrQ  = 16'h5A5A;
    smp();
    check_eq("cpu_rd_q", {16'h0000, cpuQ}, {16'h0000, rd_exp_q.pop_front()});
    nxt();
    smp();
    check_eq("cpu_q_hold", {16'h0000, cpuQ}, 32'h00A5);
    nxt();

    // Loader-only write slot.
    cpu_refresh();
    run_load(24'h020000, 16'h3C3C, -1, low, ack);
    check_eq("ld_len", low, 32'd8);
    check_eq("ld_ack", ack, 32'd1);
    smp();
    check_eq("ld_after_wr", {31'd0, sdrWr}, 32'd1);
    check_eq("ld_after_ack", {31'd0, ldAck}, 32'd0);
    nxt();

    // CPU write collides with LOAD clock 3.
    cpu_refresh();
    ldReq = 1'b1;
    ldA   = 24'h030000;
    ldD   = 16'hBEEF;
    ld_exp_q.push_back({24'h030000, 16'hBEEF});
    smp();
    nxt();
    smp();
    nxt();
    smp();
    nxt();
    cpuWr = 1'b0;
    cpuA  = 24'h0C0000;
    cpuD  = 16'h1111;
    smp();
    check_eq("coll_wait_c3", {31'd0, cpuWait}, 32'd1);
    check_eq("coll_ld_addr", {8'h00, sdrA}, 32'h030000);
    cnt = 0;
    ack = 0;
    for (int c = 4; c <= 8; c++) begin
      nxt();
      smp();
      if (cpuWait === 1'b0) cnt++;
      if (c == 8 && ldAck === 1'b1) ack = 1;
    end
    check_eq("coll_wait_low", cnt, 32'd5);
    check_eq("coll_ack_c8", ack, 32'd1);
    nxt();
    ldReq = 1'b0;
    smp();
    check_eq("coll_cpu_wr", {31'd0, sdrWr}, 32'd0);
    check_eq("coll_cpu_addr", {8'h00, sdrA}, 32'h0C0000);
    check_eq("coll_cpu_data", {16'h0000, sdrD}, 32'h1111);
    check_eq("coll_wait_hi", {31'd0, cpuWait}, 32'd1);
    nxt();
    cpuWr = 1'b1;
    smp();
    nxt();

    // Reset at LOAD clock 5 aborts the slot; held ldReq restarts it fully.
    cpu_refresh();
    ldReq = 1'b1;
    ldA   = 24'h050000;
    ldD   = 16'hA55A;
    ld_exp_q.push_back({24'h050000, 16'hA55A});
    acks0 = ack_cnt;
    smp();
    for (int c = 1; c <= 4; c++) begin
      nxt();
      smp();
    end
    nxt();
    reset = 1'b0;
    smp();
    check_eq("rst_mid_strobes", {29'd0, sdrRf, sdrRd, sdrWr}, 32'd7);
    check_eq("rst_mid_addr", {8'h00, sdrA}, 32'd0);
    check_eq("rst_mid_ack", {31'd0, ldAck}, 32'd0);
    check_eq("rst_mid_wait", {31'd0, cpuWait}, 32'd1);
    nxt();
    reset = 1'b1;
    wait_slot(-1, low, ack);
    check_eq("rst_reload_len", low, 32'd8);
    check_eq("rst_reload_acks", ack_cnt - acks0, 32'd1);

    // ldReq dropped mid-slot: slot completes with the latched address/data.
    cpu_refresh();
    run_load(24'h060000, 16'h6666, 2, low, ack);
    check_eq("drop_len", low, 32'd8);
    check_eq("drop_ack", ack, 32'd1);

    // Ready low: nothing granted, CPU not passed; then priority CPU>REFR>LOAD.
    cpu_refresh();
    ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 1040; k++) begin
      if (k == 5) cpuRd = 1'b0;
      if (k == 6) cpuRd = 1'b1;
      smp();
      if (k == 5) check_eq("notready_rd", {31'd0, sdrRd}, 32'd1);
      if (sdrRf === 1'b0 || sdrWr === 1'b0) cnt++;
      nxt();
    end
    check_eq("notready_grants", cnt, 32'd0);

    ready = 1'b1;
    cpuRd = 1'b0;
    cpuA  = 24'h014004;
    sdrQ  = 16'h7E57;
    rd_exp_q.push_back(16'h7E57);
    ldReq = 1'b1;
    ldA   = 24'h040000;
    ldD   = 16'h0F0F;
    ld_exp_q.push_back({24'h040000, 16'h0F0F});
    prev = 0;
    ack  = 0;
    for (int k = 0; k < 30; k++) begin
      smp();
      if (sdrRd === 1'b0) kind = 1;
      else if (sdrRf === 1'b0) kind = 2;
      else if (sdrWr === 1'b0) kind = 3;
      else kind = 0;
      if (kind != 0 && kind != prev) glog.push_back(kind);
      prev = kind;
      if (ldAck === 1'b1) ack = 1;
      nxt();
      if (k == 1) cpuRd = 1'b1;
      if (ack != 0) ldReq = 1'b0;
    end
    check_eq("prio_count", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      check_eq("prio_1st_cpu", glog[0], 32'd1);
      check_eq("prio_2nd_refr", glog[1], 32'd2);
      check_eq("prio_3rd_load", glog[2], 32'd3);
    end
    check_eq("prio_cpu_q", {16'h0000, cpuQ}, {16'h0000, rd_exp_q.pop_front()});

    check_eq("ld_queue_empty", 32'(ld_exp_q.size()), 32'd0);
    check_eq("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
